// File: rtl/jk_excitation_driver_if.sv
// Target-bit handshake, JK drive and flip-flop feedback bundle for jk_excitation_driver.
// master = upstream/flip-flop environment, slave = the driver itself.
interface jk_excitation_driver_if #(
  parameter int CNT_W = 8
);
  logic             tgt_valid;
  logic             tgt_bit;
  logic             tgt_ready;
  logic             q_fb;
  logic             J;
  logic             K;
  logic             q_exp;
  logic             busy;
  logic             err_pulse;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output tgt_valid, tgt_bit, q_fb,
    input  tgt_ready, J, K, q_exp, busy, err_pulse, err_cnt
  );

  modport slave (
    input  tgt_valid, tgt_bit, q_fb,
    output tgt_ready, J, K, q_exp, busy, err_pulse, err_cnt
  );
endinterface

// File: rtl/jk_excitation_driver.sv
// Encodes each desired next-Q bit into a one-clock J/K pulse and verifies Q one clock later.
// Accept->check is 2 clocks (one bit per 3 clocks); tgt_valid outside IDLE is ignored, not queued.
module jk_excitation_driver #(
  parameter int CNT_W     = 8,
  parameter int FILL_MODE = 0
) (
  input logic                   CLK,
  input logic                   CLR,
  jk_excitation_driver_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             w_tgt_ready;
  logic             w_busy;
  logic             w_accept;
  logic             w_check;
  logic             w_mismatch;
  logic             w_j_exc;
  logic             w_k_exc;

  logic             r_j;
  logic             r_k;
  logic             r_q_exp;
  logic             r_q_next;
  logic             r_err_pulse;
  logic [CNT_W-1:0] r_err_cnt;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.tgt_valid) w_state_nxt = ST_DRIVE;
      ST_DRIVE: w_state_nxt = ST_CHECK;
      ST_CHECK: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tgt_ready = (r_state == ST_IDLE);
    w_busy      = (r_state == ST_DRIVE) || (r_state == ST_CHECK);
  end

  assign w_accept = w_tgt_ready && bus.tgt_valid;

  // Excitation of the (q_exp -> tgt_bit) transition; FILL_MODE picks the don't-care value.
  always_comb begin
    if (FILL_MODE == 0) begin
      w_j_exc = ~r_q_exp &  bus.tgt_bit;
      w_k_exc =  r_q_exp & ~bus.tgt_bit;
    end else begin
      w_j_exc =   r_q_exp | bus.tgt_bit;
      w_k_exc = ~(r_q_exp & bus.tgt_bit);
    end
  end

  assign w_check    = (r_state == ST_CHECK);
  assign w_mismatch = w_check && (bus.q_fb != r_q_next);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_j         <= 1'b0;
      r_k         <= 1'b0;
      r_q_exp     <= 1'b0;
      r_q_next    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      // J/K are only ever non-zero for the single DRIVE cycle following an accept.
      r_j         <= w_accept ? w_j_exc : 1'b0;
      r_k         <= w_accept ? w_k_exc : 1'b0;
      r_err_pulse <= w_mismatch;
      if (w_accept) begin
        r_q_next <= bus.tgt_bit;
      end
      if (w_check) begin
        r_q_exp <= w_mismatch ? bus.q_fb : r_q_next;
      end
      if (w_mismatch && (r_err_cnt != {CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.tgt_ready = w_tgt_ready;
  assign bus.busy      = w_busy;
  assign bus.J         = r_j;
  assign bus.K         = r_k;
  assign bus.q_exp     = r_q_exp;
  assign bus.err_pulse = r_err_pulse;
  assign bus.err_cnt   = r_err_cnt;

endmodule
